// File: rtl/instruction_fetch_pkg.sv
// Shared constants and types for the instruction fetch stage.
// Holds the special instruction encodings and FSM states.
package instruction_fetch_pkg;

   localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;
   localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_LOAD   = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALTED = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/instruction_memory.sv
// Word-wide instruction memory.
// Synchronous write port, combinational read port, no reset.
module instruction_memory #(
   parameter int NB_DATA = 32,
   parameter int NB_ADDR = 8
) (
   input  logic               clk,
   input  logic               i_we,
   input  logic [NB_ADDR-1:0] i_waddr,
   input  logic [NB_DATA-1:0] i_wdata,
   input  logic [NB_ADDR-1:0] i_raddr,
   output logic [NB_DATA-1:0] o_rdata
);

   localparam int DEPTH = 2 ** NB_ADDR;

   logic [NB_DATA-1:0] mem [DEPTH];

   // Loader writes land on the rising edge; contents survive reset.
   always_ff @(posedge clk) begin
      if (i_we) begin
         mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage with byte loader and halt detection.
// LOAD fills memory, RUN fetches into IF/ID, HALTED idles.
module instruction_fetch
   import instruction_fetch_pkg::*;
#(
   parameter int NB_DATA      = 32,
   parameter int NB_IMEM_ADDR = 8
) (
   input  logic                  clk,
   input  logic                  i_rst_n,
   input  logic                  i_stall,
   input  logic                  i_jump,
   input  logic [NB_DATA-1:0]    i_addr2jump,
   input  logic                  i_load_valid,
   input  logic [7:0]            i_load_byte,
   input  logic                  i_start,
   output logic [NB_DATA-1:0]    o_instruction,
   output logic [NB_DATA-1:0]    o_pcounter4,
   output logic [NB_DATA-1:0]    o_pc,
   output logic                  o_halted,
   output logic                  o_load_full,
   output logic [NB_IMEM_ADDR:0] o_load_count
);

   localparam logic [NB_DATA-1:0]    PC_STEP = NB_DATA'(4);
   localparam logic [NB_DATA-1:0]    NOP_W   = NB_DATA'(NOP_INSTR);
   localparam logic [NB_DATA-1:0]    HALT_W  = NB_DATA'(HALT_INSTR);
   localparam logic [NB_IMEM_ADDR:0] CNT_ONE = 1;
   localparam logic [NB_IMEM_ADDR-1:0] PTR_ONE = 1;

   fetch_state_t            state_q;
   logic [NB_DATA-1:0]      pc_q;
   logic [NB_DATA-1:0]      instr_q;
   logic [NB_DATA-1:0]      pc4_q;
   logic                    halted_q;
   logic [NB_IMEM_ADDR:0]   count_q;
   logic [NB_IMEM_ADDR-1:0] ptr_q;
   logic [1:0]              bcnt_q;
   logic [23:0]             asm_q;

   logic [NB_DATA-1:0]      fetched;
   logic [NB_DATA-1:0]      pc_plus4;
   logic                    mem_we;
   logic                    load_full;
   logic                    take_byte;

   assign pc_plus4  = pc_q + PC_STEP;
   assign load_full = count_q[NB_IMEM_ADDR];

   // A byte is accepted only while loading, not full, and not starting.
   always_comb begin
      take_byte = 1'b0;
      mem_we    = 1'b0;
      if (state_q == ST_LOAD && !i_start &&
          i_load_valid && !load_full) begin
         take_byte = 1'b1;
         mem_we    = (bcnt_q == 2'd3);
      end
   end

   instruction_memory #(
      .NB_DATA (NB_DATA),
      .NB_ADDR (NB_IMEM_ADDR)
   ) u_imem (
      .clk     (clk),
      .i_we    (mem_we),
      .i_waddr (ptr_q),
      .i_wdata (NB_DATA'({asm_q, i_load_byte})),
      .i_raddr (pc_q[NB_IMEM_ADDR+1:2]),
      .o_rdata (fetched)
   );

   // Stage FSM: loader, fetch pipeline register and halt tracking.
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= ST_LOAD;
         pc_q     <= '0;
         instr_q  <= '0;
         pc4_q    <= '0;
         halted_q <= 1'b0;
         count_q  <= '0;
         ptr_q    <= '0;
         bcnt_q   <= '0;
         asm_q    <= '0;
      end else begin
         unique case (state_q)
            ST_LOAD: begin
               if (i_start) begin
                  state_q <= ST_RUN;
                  pc_q    <= '0;
                  bcnt_q  <= '0;
                  asm_q   <= '0;
               end else if (take_byte) begin
                  asm_q  <= {asm_q[15:0], i_load_byte};
                  bcnt_q <= bcnt_q + 2'd1;
                  if (mem_we) begin
                     ptr_q   <= ptr_q + PTR_ONE;
                     count_q <= count_q + CNT_ONE;
                  end
               end
            end
            ST_RUN: begin
               if (!i_stall) begin
                  pc4_q <= pc_plus4;
                  if (i_jump) begin
                     instr_q <= NOP_W;
                     pc_q    <= i_addr2jump;
                  end else if (fetched == HALT_W) begin
                     instr_q  <= fetched;
                     state_q  <= ST_HALTED;
                     halted_q <= 1'b1;
                  end else begin
                     instr_q <= fetched;
                     pc_q    <= pc_plus4;
                  end
               end
            end
            ST_HALTED: begin
               if (!i_stall) begin
                  instr_q <= NOP_W;
               end
               if (i_load_valid) begin
                  state_q  <= ST_LOAD;
                  halted_q <= 1'b0;
                  ptr_q    <= '0;
                  count_q  <= '0;
                  asm_q    <= {16'h0, i_load_byte};
                  bcnt_q   <= 2'd1;
               end else if (i_start) begin
                  state_q  <= ST_RUN;
                  halted_q <= 1'b0;
                  pc_q     <= '0;
               end
            end
            default: begin
               state_q <= ST_LOAD;
            end
         endcase
      end
   end

   assign o_instruction = instr_q;
   assign o_pcounter4   = pc4_q;
   assign o_pc          = pc_q;
   assign o_halted      = halted_q;
   assign o_load_full   = load_full;
   assign o_load_count  = count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch.
// Directed scenarios plus randomized fetch against a reference model.
module tb_instruction_fetch;

   localparam int NB_DATA = 32;
   localparam int NB_A    = 8;
   localparam int DEPTH   = 256;

   logic              clk = 1'b0;
   logic              i_rst_n;
   logic              i_stall;
   logic              i_jump;
   logic [31:0]       i_addr2jump;
   logic              i_load_valid;
   logic [7:0]        i_load_byte;
   logic              i_start;
   logic [31:0]       o_instruction;
   logic [31:0]       o_pcounter4;
   logic [31:0]       o_pc;
   logic              o_halted;
   logic              o_load_full;
   logic [NB_A:0]     o_load_count;

   logic [31:0] mem_m [DEPTH];
   logic [31:0] m_pc;
   logic [31:0] m_ins;
   logic [31:0] m_pc4;
   int vecs = 0;
   int errs = 0;

   instruction_fetch #(
      .NB_DATA      (NB_DATA),
      .NB_IMEM_ADDR (NB_A)
   ) dut (
      .clk           (clk),
      .i_rst_n       (i_rst_n),
      .i_stall       (i_stall),
      .i_jump        (i_jump),
      .i_addr2jump   (i_addr2jump),
      .i_load_valid  (i_load_valid),
      .i_load_byte   (i_load_byte),
      .i_start       (i_start),
      .o_instruction (o_instruction),
      .o_pcounter4   (o_pcounter4),
      .o_pc          (o_pc),
      .o_halted      (o_halted),
      .o_load_full   (o_load_full),
      .o_load_count  (o_load_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      i_rst_n = 1'b0;
      #2;
      i_rst_n = 1'b1;
      #1;
   endtask

   task automatic load_byte(input logic [7:0] b);
      i_load_valid = 1'b1;
      i_load_byte  = b;
      tick();
      i_load_valid = 1'b0;
   endtask

   task automatic load_word(input logic [31:0] w);
      for (int k = 0; k < 4; k++) begin
         load_byte(w[31-8*k -: 8]);
      end
   endtask

   task automatic start_run();
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      m_pc = 32'h0;
   endtask

   task automatic step(input logic st, input logic jp,
                       input logic [31:0] tgt);
      i_stall     = st;
      i_jump      = jp;
      i_addr2jump = tgt;
      tick();
      if (!st) begin
         m_pc4 = m_pc + 32'd4;
         m_ins = jp ? 32'h0 : mem_m[m_pc[9:2]];
         m_pc  = jp ? tgt : m_pc + 32'd4;
      end
      chk("run_pc", o_pc, m_pc);
      chk("run_instr", o_instruction, m_ins);
      chk("run_pc4", o_pcounter4, m_pc4);
      i_stall = 1'b0;
      i_jump  = 1'b0;
   endtask

   initial begin
      logic [31:0] w;
      i_rst_n      = 1'b0;
      i_stall      = 1'b0;
      i_jump       = 1'b0;
      i_addr2jump  = '0;
      i_load_valid = 1'b0;
      i_load_byte  = '0;
      i_start      = 1'b0;
      #12;
      i_rst_n = 1'b1;
      #1;

      chk("rst_pc", o_pc, 0);
      chk("rst_instr", o_instruction, 0);
      chk("rst_pc4", o_pcounter4, 0);
      chk("rst_halted", o_halted, 0);
      chk("rst_full", o_load_full, 0);
      chk("rst_count", o_load_count, 0);

      load_word(32'h0000_0020);
      load_word(32'h8C01_0004);
      load_word(32'hFFFF_FFFF);
      chk("prog_count", o_load_count, 3);
      start_run();
      chk("start_pc", o_pc, 0);
      tick();
      chk("p0_instr", o_instruction, 32'h0000_0020);
      chk("p0_pc4", o_pcounter4, 4);
      tick();
      chk("p1_instr", o_instruction, 32'h8C01_0004);
      chk("p1_pc4", o_pcounter4, 8);
      tick();
      chk("halt_instr", o_instruction, 32'hFFFF_FFFF);
      chk("halt_pc4", o_pcounter4, 12);
      chk("halt_flag", o_halted, 1);
      chk("halt_pc", o_pc, 8);
      tick();
      chk("halted_nop", o_instruction, 0);
      chk("halted_pc", o_pc, 8);
      chk("halted_flag", o_halted, 1);

      start_run();
      chk("restart_pc", o_pc, 0);
      chk("restart_halted", o_halted, 0);
      tick();
      tick();
      tick();
      chk("rehalt_instr", o_instruction, 32'hFFFF_FFFF);
      chk("rehalt_flag", o_halted, 1);
      tick();

      i_start = 1'b1;
      load_byte(8'h11);
      i_start = 1'b0;
      chk("both_halted", o_halted, 0);
      chk("both_count", o_load_count, 0);
      load_byte(8'h22);
      load_byte(8'h33);
      load_byte(8'h44);
      chk("both_word_count", o_load_count, 1);
      start_run();
      tick();
      chk("both_word0", o_instruction, 32'h1122_3344);

      do_reset();
      load_byte(8'h12);
      load_byte(8'h34);
      do_reset();
      chk("midrst_count", o_load_count, 0);
      load_word(32'hAABB_CCDD);
      chk("midrst_count1", o_load_count, 1);
      start_run();
      tick();
      chk("midrst_word0", o_instruction, 32'hAABB_CCDD);

      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
         w = $urandom;
         if (w == 32'hFFFF_FFFF) w = 32'h0;
         mem_m[i] = w;
         load_word(w);
         if (i == DEPTH - 2) chk("not_full", o_load_full, 0);
      end
      chk("full_flag", o_load_full, 1);
      chk("full_count", o_load_count, 256);
      load_word(32'hDEAD_BEEF);
      chk("drop_full", o_load_full, 1);
      chk("drop_count", o_load_count, 256);

      start_run();
      m_ins = o_instruction;
      m_pc4 = o_pcounter4;
      step(1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 32'h0);
      chk("pre_jump_pc", o_pc, 8);
      step(1'b0, 1'b1, 32'h40);
      chk("jump_nop", o_instruction, 0);
      step(1'b0, 1'b0, 32'h0);
      chk("jump_pc4", o_pcounter4, 32'h44);
      chk("jump_word16", o_instruction, mem_m[16]);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b1, 32'h100);
      end
      step(1'b0, 1'b1, 32'h100);
      chk("stall_jump_pc", o_pc, 32'h100);
      step(1'b0, 1'b1, 32'hFFFF_FFFC);
      step(1'b0, 1'b0, 32'h0);
      chk("wrap_pc", o_pc, 0);
      chk("wrap_instr", o_instruction, mem_m[255]);
      step(1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 3) == 0,
              $urandom_range(0, 4) == 0,
              $urandom);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
